mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multiply/divide unit controller for the pipelined mips core.
- Sequences one multi-cycle mult/multu/div/divu operation at a time, models fixed latency with a busy counter, and owns the HI/LO registers; also handles mthi/mtlo.
- Generates the stall request the pipeline hazard logic uses to hold the decode stage while the unit is occupied.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_LAT, 5, busy cycles for mult/multu (must be >= 1).
- DIV_LAT, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- start  input  1  one-cycle pulse from E stage: issue md_op.
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- rs_val  input  WIDTH  operand A / dividend / mthi-mtlo source.
- rt_val  input  WIDTH  operand B / divisor.
- md_use  input  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- busy  output  1  registered; operation in progress.
- hi  output  WIDTH  registered HI.
- lo  output  WIDTH  registered LO.
- stall  output  1  combinational: md_use && (busy || (start && md_op in 1..4)).

Behaviour:
- Reset (reset==0, asynchronous): busy=0, hi=0, lo=0, counter=0, pending result cleared. Reset mid-operation aborts the operation; HI/LO stay 0 after release.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, down-counter active.
- Acceptance: start sampled high at a rising edge while in IDLE.
  - start while busy=1 is ignored entirely (no HI/LO write, no restart).
  - md_op 0 or 7 with start has no effect.
- mult/multu/div/divu accepted at edge t0:
  - Operands latched and the result computed into internal pend_hi/pend_lo registers at t0.
  - Counter loaded with LAT; state moves to RUN, so busy=1 from t0 onward.
  - Counter decrements each edge while in RUN.
  - At edge t0+LAT: hi<=pend_hi, lo<=pend_lo, busy<=0, state returns to IDLE.
  - busy is therefore high for exactly LAT cycles, and new HI/LO are visible in the same cycle busy falls.
  - A new start is accepted at edge t0+LAT+1 at the earliest.
- mthi/mtlo accepted at edge t0: hi (or lo) <= rs_val at t0; busy stays 0; the other register is unchanged.
- mult: signed 2*WIDTH product. multu: unsigned product. hi = upper WIDTH bits, lo = lower WIDTH bits.
- div (signed):
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Overflow case (-2^(WIDTH-1) / -1): lo=0x80000000, hi=0.
- divu: unsigned quotient in lo, remainder in hi.
- Divide by zero (either div or divu): busy runs its full DIV_LAT cycles, then hi/lo are left unchanged.
- stall: pure combinational, no latency. Covers both a busy unit and an issue in the current cycle.

Test Plan:
- Reset: hold reset=0 for 5 cycles with start=1, md_op=1 -> busy=0, hi=0, lo=0 throughout; after release with start=0, no change.
- Signed mult: rs=3, rt=0xFFFFFFFE, start mult -> busy=1 for exactly 5 cycles; when busy falls hi=0xFFFFFFFF, lo=0xFFFFFFFA. Same operands with multu -> hi=0x00000002, lo=0xFFFFFFFA.
- Signed div: rs=0xFFFFFFF9 (-7), rt=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div overflow: 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu by zero: preload hi=0x11 and lo=0x22 via mthi/mtlo, then divu rs=5, rt=0 -> busy for 10 cycles, then hi=0x11, lo=0x22.
- Busy interactions:
  - During mult, start mtlo rs=0xAA -> ignored, lo = product.
  - During mult, md_use=1 -> stall=1 every busy cycle, stall=0 the cycle busy falls.
  - Assert reset=0 mid-div -> busy=0, hi=lo=0 immediately.

Source files
------------

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide unit controller with HI/LO ownership and stall generation
module mdu_ctrl #(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             md_use,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             stall
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] pend_hi;
    logic [WIDTH-1:0] pend_lo;
    logic             pend_wr;

    logic             is_md;
    logic             is_div;
    logic             div_zero;

    logic [2*WIDTH-1:0] a_sx;
    logic [2*WIDTH-1:0] b_sx;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    assign is_md    = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    assign is_div   = (md_op == OP_DIV) || (md_op == OP_DIVU);
    assign div_zero = (rt_val == '0);

    // Low 2*WIDTH bits of a product of sign-extended operands equal the signed product.
    assign a_sx   = {{WIDTH{rs_val[WIDTH-1]}}, rs_val};
    assign b_sx   = {{WIDTH{rt_val[WIDTH-1]}}, rt_val};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {{WIDTH{1'b0}}, rs_val} * {{WIDTH{1'b0}}, rt_val};

    // One unsigned divider serves both div and divu; signed div runs on magnitudes.
    // The most-negative dividend over -1 falls out as quotient 0x80..0 with no special case.
    assign a_neg = rs_val[WIDTH-1];
    assign b_neg = rt_val[WIDTH-1];
    assign a_mag = a_neg ? (~rs_val + WIDTH'(1)) : rs_val;
    assign b_mag = b_neg ? (~rt_val + WIDTH'(1)) : rt_val;
    assign div_a = (md_op == OP_DIV) ? a_mag : rs_val;
    assign div_b = div_zero ? WIDTH'(1) : ((md_op == OP_DIV) ? b_mag : rt_val);
    assign quo   = div_a / div_b;
    assign rem   = div_a % div_b;

    // Select the result that will be parked in pend_hi/pend_lo at issue.
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (md_op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                res_lo = (a_neg ^ b_neg) ? (~quo + WIDTH'(1)) : quo;
                res_hi = a_neg ? (~rem + WIDTH'(1)) : rem;
            end
            OP_DIVU: begin
                res_lo = quo;
                res_hi = rem;
            end
            default: ;
        endcase
    end

    // Issue, latency countdown and HI/LO update; starts during RUN are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_md) begin
                            pend_hi <= res_hi;
                            pend_lo <= res_lo;
                            pend_wr <= !(is_div && div_zero);
                            cnt     <= is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
                            state   <= S_RUN;
                        end else if (md_op == OP_MTHI) begin
                            hi <= rs_val;
                        end else if (md_op == OP_MTLO) begin
                            lo <= rs_val;
                        end
                    end
                end
                S_RUN: begin
                    if (cnt == CW'(1)) begin
                        if (pend_wr) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy  = (state == S_RUN);
    assign stall = md_use && (busy || (start && is_md));

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - scoreboard bench for mdu_ctrl
module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;
    logic [63:0] sb[$];

    mdu_ctrl #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .md_use (md_use),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .stall  (stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Reference result {hi,lo}; divide by zero leaves the current HI/LO.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb_;
        longint q;
        longint r;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        p   = {mhi, mlo};
        case (op)
            3'd1: p = 64'(sa * sb_);
            3'd2: p = {32'd0, a} * {32'd0, b};
            3'd3: if (b != 0) begin
                q = sa / sb_;
                r = sa % sb_;
                p = {r[31:0], q[31:0]};
            end
            3'd4: if (b != 0) p = {a % b, a / b};
            default: ;
        endcase
        return p;
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit inject);
        int n;
        int lat;
        logic [63:0] exp;
        lat = (op >= 3'd3) ? 10 : 5;
        exp = model(op, a, b);
        sb.push_back(exp);
        {mhi, mlo} = exp;
        @(negedge clk);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        md_use = 1'b1;
        #1 check("stall_issue", 64'(stall), 64'd1);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            check("stall_busy", 64'(stall), 64'd1);
            n++;
            if (inject && n == 2) begin
                start  = 1'b1;
                md_op  = 3'd6;
                rs_val = 32'hAA;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("busy_cycles", 64'(n), 64'(lat));
        check("stall_fall", 64'(stall), 64'd0);
        md_use = 1'b0;
        md_op  = 3'd0;
        if (sb.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            exp = sb.pop_front();
            check("hilo", {hi, lo}, exp);
        end
    endtask

    task automatic move(input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        if (op == 3'd5) mhi = a;
        if (op == 3'd6) mlo = a;
        check("move_busy", 64'(busy), 64'd0);
        check("move_hilo", {hi, lo}, {mhi, mlo});
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b1;
        md_op  = 3'd1;
        rs_val = 32'd3;
        rt_val = 32'd5;
        md_use = 1'b0;

        repeat (5) begin
            @(negedge clk);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_hilo", {hi, lo}, 64'd0);
        end
        start  = 1'b0;
        md_op  = 3'd0;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        check("rel_busy", 64'(busy), 64'd0);
        check("rel_hilo", {hi, lo}, 64'd0);

        run_op(3'd1, 32'd3, 32'hFFFFFFFE, 1'b0);
        check("mult_c", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        run_op(3'd2, 32'd3, 32'hFFFFFFFE, 1'b0);
        check("multu_c", {hi, lo}, 64'h00000002_FFFFFFFA);
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("div_c", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("div_ovf_c", {hi, lo}, 64'h00000000_80000000);

        move(3'd5, 32'h11);
        move(3'd6, 32'h22);
        run_op(3'd4, 32'd5, 32'd0, 1'b0);
        check("divu0_c", {hi, lo}, 64'h00000011_00000022);

        run_op(3'd1, 32'h1234, 32'h5678, 1'b1);
        check("mtlo_ignored", 64'(lo), 64'(32'h1234 * 32'h5678));

        // Reserved op with start must do nothing and must not stall.
        @(negedge clk);
        start  = 1'b1;
        md_op  = 3'd7;
        rs_val = 32'hDEAD;
        md_use = 1'b1;
        #1 check("op7_stall", 64'(stall), 64'd0);
        @(negedge clk);
        start  = 1'b0;
        md_use = 1'b0;
        check("op7_busy", 64'(busy), 64'd0);
        check("op7_hilo", {hi, lo}, {mhi, mlo});

        for (int i = 0; i < 6; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'($urandom_range(1, 4));
            a  = $urandom;
            b  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 50)) : $urandom);
            run_op(op, a, b, 1'b0);
        end

        // Reset in the middle of a divide.
        @(negedge clk);
        start  = 1'b1;
        md_op  = 3'd3;
        rs_val = 32'd100;
        rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        mhi = '0;
        mlo = '0;
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_hilo", {hi, lo}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
